// File: rtl/readout_sequencer.sv
// readout_sequencer: trigger-driven readout FSM for one measurement shot.
// Each shot runs IDLE -> DELAY -> COLLECT -> WAIT_IQ -> OUT. DELAY waits for
// the programmed delay, COLLECT opens the sampler window, WAIT_IQ waits for
// the integrator result, and OUT holds that result until it is accepted.
// Optional feature macro: READOUT_TRIG_PEND_EN. When defined, one trigger that
// arrives while a shot is running is queued instead of being reported as an
// overrun.
module readout_sequencer #(
    parameter int TIMEOUT = 4096,
    parameter int SHOT_W  = 16
) (
    input  logic              clk100,
    input  logic              reset_n,
    input  logic              trigger,
    input  logic [13:0]       delay_time,
    input  logic [10:0]       sample_length,
    input  logic              iq_valid,
    input  logic [31:0]       i_val,
    input  logic [31:0]       q_val,
    input  logic              res_ready,
    output logic              start_collect,
    output logic              collect_en,
    output logic              res_valid,
    output logic [31:0]       res_i,
    output logic [31:0]       res_q,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              err_cfg,
    output logic [SHOT_W-1:0] shot_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DELAY   = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_WAIT_IQ = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    // One down-counter is shared by DELAY, COLLECT and WAIT_IQ. It must be wide
    // enough for both the 14-bit delay and the timeout value.
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TO_W > 14) ? TO_W : 14;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TO_LOAD  = CNT_W'(TIMEOUT - 1);
    localparam logic [SHOT_W-1:0] SHOT_ONE = SHOT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [10:0]       len_q, len_d;
    logic              first_q, first_d;
    logic              trigger_q;
    logic [31:0]       ri_q, ri_d;
    logic [31:0]       rq_q, rq_d;
    logic [SHOT_W-1:0] shot_q, shot_d;
    logic              err_ovr_q, err_ovr_d;
    logic              err_to_q, err_to_d;
    logic              err_cfg_q, err_cfg_d;
    logic              trig_rise;
    logic              start_req;

`ifdef READOUT_TRIG_PEND_EN
    logic              pend_q, pend_d;
    logic              go_q, go_d;
`endif

    assign trig_rise = trigger & ~trigger_q;

`ifdef READOUT_TRIG_PEND_EN
    // A queued trigger is replayed in the first IDLE cycle after the shot ends.
    assign start_req = trig_rise | go_q;
`else
    assign start_req = trig_rise;
`endif

    // Compute the next state, counters, result capture and error pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        first_d   = 1'b0;
        ri_d      = ri_q;
        rq_d      = rq_q;
        shot_d    = shot_q;
        err_ovr_d = 1'b0;
        err_to_d  = 1'b0;
        err_cfg_d = 1'b0;
`ifdef READOUT_TRIG_PEND_EN
        pend_d    = pend_q;
        go_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    len_d = sample_length;
                    if (sample_length == 11'd0) begin
                        err_cfg_d = 1'b1;
                    end else if (delay_time != 14'd0) begin
                        state_d = S_DELAY;
                        cnt_d   = CNT_W'(delay_time) - CNT_ONE;
                    end else begin
                        state_d = S_COLLECT;
                        cnt_d   = CNT_W'(sample_length) - CNT_ONE;
                        first_d = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_COLLECT;
                    cnt_d   = CNT_W'(len_q) - CNT_ONE;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_COLLECT: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT_IQ;
                    cnt_d   = TO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_IQ: begin
                if (iq_valid) begin
                    state_d = S_OUT;
                    ri_d    = i_val;
                    rq_d    = q_val;
                end else if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    shot_d  = shot_q + SHOT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Triggers that arrive mid-shot are either queued once or reported.
        if (state_q != S_IDLE && trig_rise) begin
`ifdef READOUT_TRIG_PEND_EN
            if (!pend_q) pend_d    = 1'b1;
            else         err_ovr_d = 1'b1;
`else
            err_ovr_d = 1'b1;
`endif
        end
`ifdef READOUT_TRIG_PEND_EN
        if (state_q != S_IDLE && state_d == S_IDLE && pend_d) begin
            pend_d = 1'b0;
            go_d   = 1'b1;
        end
`endif
    end

    // State registers. A trigger held high through reset is not seen as an edge.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            first_q   <= 1'b0;
            trigger_q <= 1'b1;
            ri_q      <= '0;
            rq_q      <= '0;
            shot_q    <= '0;
            err_ovr_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_cfg_q <= 1'b0;
`ifdef READOUT_TRIG_PEND_EN
            pend_q    <= 1'b0;
            go_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            first_q   <= first_d;
            trigger_q <= trigger;
            ri_q      <= ri_d;
            rq_q      <= rq_d;
            shot_q    <= shot_d;
            err_ovr_q <= err_ovr_d;
            err_to_q  <= err_to_d;
            err_cfg_q <= err_cfg_d;
`ifdef READOUT_TRIG_PEND_EN
            pend_q    <= pend_d;
            go_q      <= go_d;
`endif
        end
    end

    // Outputs are decoded from registered state only. In particular, res_valid
    // never looks at res_ready.
    assign busy          = (state_q != S_IDLE);
    assign collect_en    = (state_q == S_COLLECT);
    assign start_collect = collect_en & first_q;
    assign res_valid     = (state_q == S_OUT);
    assign res_i         = ri_q;
    assign res_q         = rq_q;
    assign err_overrun   = err_ovr_q;
    assign err_timeout   = err_to_q;
    assign err_cfg       = err_cfg_q;
    assign shot_cnt      = shot_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer (TIMEOUT=16). Cycle k counts edges
// after the trigger cycle k=0. Outputs are sampled 1ns after each rising edge.
module tb_readout_sequencer;

    logic        clk100 = 1'b0;
    logic        reset_n;
    logic        trigger;
    logic [13:0] delay_time;
    logic [10:0] sample_length;
    logic        iq_valid;
    logic [31:0] i_val, q_val;
    logic        res_ready;
    logic        start_collect, collect_en, res_valid, busy;
    logic [31:0] res_i, res_q;
    logic        err_overrun, err_timeout, err_cfg;
    logic [15:0] shot_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Flag vector: {start_collect, collect_en, busy, res_valid, err_overrun, err_timeout, err_cfg}
    logic [6:0] obs, exp_v;
    assign obs = {start_collect, collect_en, busy, res_valid, err_overrun, err_timeout, err_cfg};

    readout_sequencer #(.TIMEOUT(16), .SHOT_W(16)) dut (
        .clk100(clk100), .reset_n(reset_n), .trigger(trigger),
        .delay_time(delay_time), .sample_length(sample_length),
        .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val), .res_ready(res_ready),
        .start_collect(start_collect), .collect_en(collect_en), .res_valid(res_valid),
        .res_i(res_i), .res_q(res_q), .busy(busy),
        .err_overrun(err_overrun), .err_timeout(err_timeout), .err_cfg(err_cfg),
        .shot_cnt(shot_cnt)
    );

    always #5 clk100 = ~clk100;

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trigger = 1'b1; delay_time = '0; sample_length = '0;
        iq_valid = 1'b0; i_val = '0; q_val = '0; res_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (obs !== 7'b0) begin n_errors++; $display("FAIL reset_flags got %b want %b", obs, 7'b0); end
        n_checks++;
        if (shot_cnt !== 16'd0 || res_i !== 32'd0 || res_q !== 32'd0) begin
            n_errors++; $display("FAIL reset_data got shot=%0d i=%h q=%h want 0", shot_cnt, res_i, res_q);
        end
        // Release reset with trigger still high: this must not start a shot.
        sample_length = 11'd4;
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (obs !== 7'b0) begin n_errors++; $display("FAIL reset_held_trig k=%0d got %b want %b", k, obs, 7'b0); end
        end
        trigger = 1'b0;
        tick();
    endtask

    // delay 5, window 20, iq 3 cycles after window end; config changes mid-shot are ignored.
    task automatic test_basic_shot();
        delay_time = 14'd5; sample_length = 11'd20; res_ready = 1'b1;
        trigger = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            exp_v = {k == 6, (k >= 6 && k <= 25), (k >= 1 && k <= 29), k == 29, 3'b000};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL basic_flags k=%0d got %b want %b", k, obs, exp_v); end
            if (k == 29) begin
                n_checks++;
                if (res_i !== 32'hDEAD_0001 || res_q !== 32'hBEEF_0002) begin
                    n_errors++; $display("FAIL basic_data got %h/%h want deadbeef pair", res_i, res_q);
                end
            end
            if (k == 3) trigger = 1'b0;
            if (k == 2) begin delay_time = 14'd100; sample_length = 11'd3; end
            if (k == 28) begin iq_valid = 1'b1; i_val = 32'hDEAD_0001; q_val = 32'hBEEF_0002; end
            if (k == 29) begin iq_valid = 1'b0; i_val = '0; q_val = '0; end
        end
        n_checks++;
        if (shot_cnt !== 16'd1) begin n_errors++; $display("FAIL basic_shot_cnt got %0d want 1", shot_cnt); end
    endtask

    // delay 0, window 1; iq_valid before WAIT_IQ is ignored, then timeout.
    task automatic test_min_window_timeout();
        delay_time = 14'd0; sample_length = 11'd1;
        trigger = 1'b1; iq_valid = 1'b1; i_val = 32'h1111_1111; q_val = 32'h2222_2222;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_v = {k == 1, k == 1, (k >= 1 && k <= 17), 1'b0, 1'b0, k == 18, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL minwin_timeout k=%0d got %b want %b", k, obs, exp_v); end
            if (k == 1) trigger = 1'b0;
            if (k == 2) iq_valid = 1'b0;
        end
        n_checks++;
        if (shot_cnt !== 16'd1 || res_i !== 32'hDEAD_0001) begin
            n_errors++; $display("FAIL timeout_nochange got shot=%0d i=%h want 1/dead0001", shot_cnt, res_i);
        end
    endtask

    task automatic test_cfg_error();
        delay_time = 14'd3; sample_length = 11'd0;
        trigger = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_v = {6'b000000, k == 1};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL cfg_err k=%0d got %b want %b", k, obs, exp_v); end
            if (k == 1) trigger = 1'b0;
        end
    endtask

    // Backpressure for 10 cycles with a trigger arriving during OUT.
    task automatic test_back_to_back();
        delay_time = 14'd0; sample_length = 11'd2; res_ready = 1'b0;
        trigger = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            tick();
`ifdef READOUT_TRIG_PEND_EN
            exp_v = {k == 17, (k >= 17 && k <= 19), ((k >= 1 && k <= 13) || (k >= 15 && k <= 35)),
                     (k >= 4 && k <= 13), 1'b0, k == 36, 1'b0};
`else
            exp_v = {k == 1, (k >= 1 && k <= 2), (k >= 1 && k <= 13), (k >= 4 && k <= 13), k == 7, 2'b00};
`endif
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL backpressure k=%0d got %b want %b", k, obs, exp_v); end
            if (k >= 4 && k <= 13) begin
                n_checks++;
                if (res_i !== 32'hCAFE_0003 || res_q !== 32'hF00D_0004) begin
                    n_errors++; $display("FAIL hold_data k=%0d got %h/%h want cafe0003/f00d0004", k, res_i, res_q);
                end
            end
            if (k == 14) begin
                n_checks++;
                if (shot_cnt !== 16'd2) begin n_errors++; $display("FAIL handshake_cnt got %0d want 2", shot_cnt); end
            end
            if (k == 1) trigger = 1'b0;
            if (k == 3) begin iq_valid = 1'b1; i_val = 32'hCAFE_0003; q_val = 32'hF00D_0004; end
            if (k == 4) begin i_val = 32'h5555_5555; q_val = 32'h6666_6666; end
            if (k == 5) iq_valid = 1'b0;
            if (k == 6) begin trigger = 1'b1; delay_time = 14'd2; sample_length = 11'd3; end
            if (k == 7) trigger = 1'b0;
            if (k == 13) res_ready = 1'b1;
        end
        n_checks++;
        if (shot_cnt !== 16'd2) begin n_errors++; $display("FAIL b2b_final_cnt got %0d want 2", shot_cnt); end
    endtask

    // Reset pulsed during COLLECT aborts the shot immediately.
    task automatic test_reset_mid_shot();
        delay_time = 14'd1; sample_length = 11'd10; res_ready = 1'b1;
        trigger = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_v = {k == 2, (k >= 2), 1'b1, 4'b0000};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL pre_abort k=%0d got %b want %b", k, obs, exp_v); end
            if (k == 1) trigger = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b0 || shot_cnt !== 16'd0) begin
            n_errors++; $display("FAIL abort_now got %b shot=%0d want 0000000 shot=0", obs, shot_cnt);
        end
        iq_valid = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (obs !== 7'b0 || shot_cnt !== 16'd0) begin
                n_errors++; $display("FAIL post_abort k=%0d got %b shot=%0d want 0000000 shot=0", k, obs, shot_cnt);
            end
            if (k == 1) iq_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_shot();
        test_min_window_timeout();
        test_cfg_error();
        test_back_to_back();
        test_reset_mid_shot();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
